// File: rtl/execute_shift_left_seq.sv
// execute_shift_left_seq: iterative SHL/SAL, ROL and RCL execution unit with
// x86 CF/OF semantics and valid/ready handshakes on the request and result sides.
// A request is latched on accept. The SHIFT state then walks the single-bit
// steps, and DONE presents the result until the consumer takes it.
// Optional build macro EXECUTE_SHIFT_LEFT_SINGLE_CYCLE_EN: SHIFT completes all
// steps in one cycle and STEP is ignored.
module execute_shift_left_seq #(
    parameter int BIT_WIDTH = 32,
    parameter int STEP      = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [1:0]           in_size,
    input  logic [BIT_WIDTH-1:0] in_operand,
    input  logic [7:0]           in_count,
    input  logic                 in_cf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_result,
    output logic                 out_cf,
    output logic                 out_of,
    output logic                 out_cf_we,
    output logic                 out_of_we
);

`ifdef EXECUTE_SHIFT_LEFT_SINGLE_CYCLE_EN
    localparam int LP_SPC = BIT_WIDTH;
`else
    localparam int LP_SPC = STEP;
`endif

    localparam logic [1:0] LP_OP_SHL = 2'd0;
    localparam logic [1:0] LP_OP_ROL = 2'd1;
    localparam logic [1:0] LP_OP_RCL = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [BIT_WIDTH-1:0] r_val;
    logic                 r_cf;
    logic [1:0]           r_op;
    logic [1:0]           r_size;
    logic [4:0]           r_c;
    logic [4:0]           r_rem;
    logic [BIT_WIDTH-1:0] w_val_nxt;
    logic                 w_cf_nxt;
    logic [4:0]           w_rem_nxt;
    logic [4:0]           w_c;
    logic [4:0]           w_n;
    logic                 w_accept;
    logic                 w_unused_cnt;

    // Mask of the bits that belong to the selected operand size.
    function automatic logic [BIT_WIDTH-1:0] f_mask(input logic [1:0] size);
        case (size)
            2'd0:    return BIT_WIDTH'(32'h0000_00FF);
            2'd1:    return BIT_WIDTH'(32'h0000_FFFF);
            default: return {BIT_WIDTH{1'b1}};
        endcase
    endfunction

    // Most significant bit of the value at the selected operand size.
    function automatic logic f_msb(input logic [BIT_WIDTH-1:0] val, input logic [1:0] size);
        case (size)
            2'd0:    return val[7];
            2'd1:    return val[15];
            default: return val[BIT_WIDTH-1];
        endcase
    endfunction

    // Effective step count: rotates wrap at size (ROL) or size+1 (RCL).
    function automatic logic [4:0] f_eff_count(input logic [1:0] op, input logic [1:0] size,
                                               input logic [4:0] c);
        logic [4:0] n;
        n = c;
        if (op == LP_OP_ROL) begin
            case (size)
                2'd0:    n = c & 5'h07;
                2'd1:    n = c & 5'h0F;
                default: n = c;
            endcase
        end else if (op == LP_OP_RCL) begin
            case (size)
                2'd0:    n = c % 5'd9;
                2'd1:    n = c % 5'd17;
                default: n = c;
            endcase
        end
        return n;
    endfunction

    // One single-bit left step. Returns {new CF, new value}.
    function automatic logic [BIT_WIDTH:0] f_step(input logic [BIT_WIDTH-1:0] val, input logic cf,
                                                  input logic [1:0] op, input logic [1:0] size);
        logic                 msb;
        logic                 lsb;
        logic [BIT_WIDTH-1:0] sh;
        msb = f_msb(val, size);
        case (op)
            LP_OP_ROL: lsb = msb;
            LP_OP_RCL: lsb = cf;
            default:   lsb = 1'b0;
        endcase
        sh = {val[BIT_WIDTH-2:0], lsb} & f_mask(size);
        return {msb, sh};
    endfunction

    assign w_c          = in_count[4:0];
    assign w_unused_cnt = ^in_count[7:5];
    assign w_n          = f_eff_count(in_op, in_size, w_c);
    assign w_accept     = in_valid && (r_state == ST_IDLE);

    // Apply up to LP_SPC single-bit steps this cycle, limited by the steps remaining.
    always_comb begin
        w_val_nxt = r_val;
        w_cf_nxt  = r_cf;
        for (int i = 0; i < LP_SPC; i++) begin
            if (i < int'(r_rem)) begin
                {w_cf_nxt, w_val_nxt} = f_step(w_val_nxt, w_cf_nxt, r_op, r_size);
            end
        end
        if (int'(r_rem) <= LP_SPC) begin
            w_rem_nxt = 5'd0;
        end else begin
            w_rem_nxt = r_rem - 5'(LP_SPC);
        end
    end

    // State register; reset discards any in-flight operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake/result outputs; results are only driven in DONE.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_result  = '0;
        out_cf      = 1'b0;
        out_of      = 1'b0;
        out_cf_we   = 1'b0;
        out_of_we   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = (w_n != 5'd0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (w_rem_nxt == 5'd0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid  = 1'b1;
                out_result = r_val;
                out_cf     = r_cf;
                out_of     = f_msb(r_val, r_size) ^ r_cf;
                out_cf_we  = (r_c != 5'd0);
                out_of_we  = (r_c == 5'd1);
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand latch on accept, then iterate while in SHIFT.
    // The CF seed covers the no-op rotate cases: ROL reports operand bit 0, RCL keeps in_cf.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_val  <= in_operand & f_mask(in_size);
            r_op   <= (in_op == 2'd3) ? LP_OP_SHL : in_op;
            r_size <= in_size;
            r_c    <= w_c;
            r_rem  <= w_n;
            case (in_op)
                LP_OP_ROL: r_cf <= in_operand[0];
                LP_OP_RCL: r_cf <= in_cf;
                default:   r_cf <= 1'b0;
            endcase
        end else if (r_state == ST_SHIFT) begin
            r_val <= w_val_nxt;
            r_cf  <= w_cf_nxt;
            r_rem <= w_rem_nxt;
        end
    end

endmodule

// File: tb/tb_execute_shift_left_seq.sv
// Directed testbench for execute_shift_left_seq (default build, STEP=1).
module tb_execute_shift_left_seq;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [1:0]  in_size;
    logic [31:0] in_operand;
    logic [7:0]  in_count;
    logic        in_cf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_cf;
    logic        out_of;
    logic        out_cf_we;
    logic        out_of_we;

    int n_tests = 0;
    int n_fail  = 0;

    execute_shift_left_seq #(.BIT_WIDTH(32), .STEP(1)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_size    (in_size),
        .in_operand (in_operand),
        .in_count   (in_count),
        .in_cf      (in_cf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_cf     (out_cf),
        .out_of     (out_of),
        .out_cf_we  (out_cf_we),
        .out_of_we  (out_of_we)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one request and return the cycles from accept edge to out_valid.
    task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic [31:0] operand,
                         input logic [7:0] count, input logic cf, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clock); #1; w++;
        end
        check("issue_in_ready", 32'(in_ready), 32'd1);
        in_op      = op;
        in_size    = size;
        in_operand = operand;
        in_count   = count;
        in_cf      = cf;
        in_valid   = 1'b1;
        @(posedge clock); #1;
        in_valid   = 1'b0;
        in_operand = 32'hDEAD_BEEF;
        in_count   = 8'hFF;
        in_op      = 2'd1;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clock); #1; lat++;
        end
    endtask

    // Complete the result handshake and confirm return to IDLE.
    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [1:0] size,
                       input logic [31:0] operand, input logic [7:0] count, input logic cf,
                       input logic [31:0] e_res, input logic e_cf, input logic e_of,
                       input logic e_cfwe, input logic e_ofwe, input int e_lat);
        int lat;
        issue(op, size, operand, count, cf, lat);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".lat"},   32'(lat), 32'(e_lat));
        check({tag, ".res"},   out_result, e_res);
        check({tag, ".cf_we"}, 32'(out_cf_we), 32'(e_cfwe));
        check({tag, ".of_we"}, 32'(out_of_we), 32'(e_ofwe));
        if (e_cfwe) check({tag, ".cf"}, 32'(out_cf), 32'(e_cf));
        if (e_ofwe) check({tag, ".of"}, 32'(out_of), 32'(e_of));
        release_out(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_op      = 2'd0;
        in_size    = 2'd0;
        in_operand = 32'd0;
        in_count   = 8'd0;
        in_cf      = 1'b0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst.in_ready",  32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.result",    out_result, 32'd0);
        check("rst.flags",     {28'd0, out_cf, out_of, out_cf_we, out_of_we}, 32'd0);

        //   tag               op    size  operand         count  cf    res           cf    of    cfwe  ofwe  lat
        run("t1_shl32_c1",     2'd0, 2'd2, 32'h8000_0001, 8'd1,  1'b0, 32'h0000_0002, 1'b1, 1'b1, 1'b1, 1'b1, 2);
        run("t2_shl8_c9",      2'd0, 2'd0, 32'h0000_0001, 8'd9,  1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 10);
        run("t2_shl8_c8",      2'd0, 2'd0, 32'h0000_0001, 8'd8,  1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 9);
        run("t3_rol8_c8",      2'd1, 2'd0, 32'h0000_0081, 8'd8,  1'b0, 32'h0000_0081, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        run("t3_rcl8_c1",      2'd2, 2'd0, 32'h0000_0080, 8'd1,  1'b1, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 1'b1, 2);
        run("t4_shl32_c32",    2'd0, 2'd2, 32'h1234_5678, 8'h20, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        run("t7_shl16_mask",   2'd0, 2'd1, 32'hABCD_8001, 8'd1,  1'b0, 32'h0000_0002, 1'b1, 1'b1, 1'b1, 1'b1, 2);
        run("t8_rcl8_noop0",   2'd2, 2'd0, 32'h0000_005A, 8'd9,  1'b0, 32'h0000_005A, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        run("t9_rcl8_noop1",   2'd2, 2'd0, 32'hFFFF_FF5A, 8'd9,  1'b1, 32'h0000_005A, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        run("t10_rol32_c36",   2'd1, 2'd2, 32'h8000_0001, 8'h24, 1'b0, 32'h0000_0018, 1'b0, 1'b0, 1'b1, 1'b0, 5);
        run("t11_op3_size3",   2'd3, 2'd3, 32'h4000_0000, 8'd2,  1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 3);

        // Result held while the consumer stalls.
        issue(2'd1, 2'd1, 32'h0000_8001, 8'd4, 1'b0, lat);
        check("t5.lat", 32'(lat), 32'd5);
        for (int k = 0; k < 5; k++) begin
            check("t5.hold_valid", 32'(out_valid), 32'd1);
            check("t5.hold_res",   out_result, 32'h0000_0018);
            check("t5.hold_cf",    32'(out_cf), 32'd0);
            check("t5.hold_ready", 32'(in_ready), 32'd0);
            @(posedge clock); #1;
        end
        release_out("t5");

        // Reset in the third SHIFT cycle of a long shift.
        in_op      = 2'd0;
        in_size    = 2'd2;
        in_operand = 32'hFFFF_FFFF;
        in_count   = 8'd31;
        in_cf      = 1'b0;
        in_valid   = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("t6.mid_shift_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("t6.rst_valid",  32'(out_valid), 32'd0);
        check("t6.rst_ready",  32'(in_ready), 32'd1);
        check("t6.rst_result", out_result, 32'd0);
        check("t6.rst_flags",  {28'd0, out_cf, out_of, out_cf_we, out_of_we}, 32'd0);
        run("t6_shl32_c2",     2'd0, 2'd2, 32'h0000_0001, 8'd2,  1'b0, 32'h0000_0004, 1'b0, 1'b0, 1'b1, 1'b0, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
